dvp_led_pwm_pio: RTL and testbench

Parametrised Avalon-MM output PIO for board LEDs, the next-generation replacement for the fixed 4-bit LED port in the DVP capture core. It adds configurable width, atomic bit set/clear, per-bit hardware blink with a programmable prescaler, global PWM brightness and output polarity. It sits on the core's Avalon-MM interconnect as a zero-wait-state slave and drives LED pins directly.

---
 rtl/dvp_led_pkg.sv | 20 ++
 rtl/dvp_led_tick_gen.sv | 49 ++++
 rtl/dvp_led_pwm_pio.sv | 96 +++++++++
 tb/tb_dvp_led_pwm_pio.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dvp_led_pkg.sv
// Shared register map and field definitions for the LED PIO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dvp_led_pkg;

  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_SET      = 3'd1;
  localparam logic [2:0] REG_CLR      = 3'd2;
  localparam logic [2:0] REG_BLINK    = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_DUTY     = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_RESERVED = 3'd7;

  localparam int PRESCALE_W = 24;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_BIT   = 1;

endpackage

// File: rtl/dvp_led_tick_gen.sv
// Blink prescaler (phase toggle) and free-running PWM counter/compare.
// Latency: phase/pre_cnt update on the clock edge; pwm_on is combinational from pwm_cnt and duty.
// Backpressure: none; free-running, prescale_load restarts the prescale count.
module dvp_led_tick_gen
  import dvp_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic                  prescale_load,
  output logic                  phase,
  output logic                  pwm_on
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;

  // Prescaler: a PRESCALE write restarts the count without disturbing phase,
  // so a lowered PRESCALE can never leave pre_cnt above the wrap point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      phase   <= 1'b1;
    end else if (prescale_load) begin
      pre_cnt <= '0;
    end else if (pre_cnt == prescale) begin
      pre_cnt <= '0;
      phase   <= ~phase;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // PWM counter wraps naturally modulo 2^PWM_BITS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // All-ones duty forces full-on so the top count never produces a dark cycle.
  assign pwm_on = (&duty) | (pwm_cnt < duty);

endmodule

// File: rtl/dvp_led_pwm_pio.sv
// Avalon-MM LED output PIO with set/clear, hardware blink, PWM brightness and polarity.
// Latency: register write lands on the next edge; out_port follows one edge later.
// Backpressure: none; zero-wait-state slave, writes always accepted, reads are combinational.
module dvp_led_pwm_pio
  import dvp_led_pkg::*;
#(
  parameter int                    WIDTH          = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE    = '0,
  parameter int                    PWM_BITS       = 8,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RESET = 24'd12_499_999,
  parameter bit                    INVERT         = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      blink;
  logic [PRESCALE_W-1:0] prescale;
  logic [PWM_BITS-1:0]   duty;
  logic [WIDTH-1:0]      wdata;
  logic                  wr_en;
  logic                  prescale_load;
  logic                  phase;
  logic                  pwm_on;
  logic                  unused_wdata;

  assign wr_en         = chipselect & ~write_n;
  assign wdata         = writedata[WIDTH-1:0];
  assign prescale_load = wr_en && (address == REG_PRESCALE);
  assign unused_wdata  = ^writedata;

  // Register file; only one address per cycle, so SET and CLR never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data     <= RESET_VALUE;
      blink    <= '0;
      prescale <= PRESCALE_RESET;
      duty     <= '1;
    end else if (wr_en) begin
      case (address)
        REG_DATA:     data     <= wdata;
        REG_SET:      data     <= data | wdata;
        REG_CLR:      data     <= data & ~wdata;
        REG_BLINK:    blink    <= wdata;
        REG_PRESCALE: prescale <= writedata[PRESCALE_W-1:0];
        REG_DUTY:     duty     <= writedata[PWM_BITS-1:0];
        default:      ;
      endcase
    end
  end

  dvp_led_tick_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_tick_gen (
    .clk           (clk),
    .reset         (reset),
    .prescale      (prescale),
    .duty          (duty),
    .prescale_load (prescale_load),
    .phase         (phase),
    .pwm_on        (pwm_on)
  );

  // Registered pin drive: blinking bits gated by phase, everything gated by PWM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port <= RESET_VALUE ^ {WIDTH{INVERT}};
    end else begin
      out_port <= {WIDTH{INVERT}} ^ (data & (~blink | {WIDTH{phase}}) & {WIDTH{pwm_on}});
    end
  end

  // Read decode; SET, CLR and the reserved slot read back as zero.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:     readdata[WIDTH-1:0]      = data;
      REG_BLINK:    readdata[WIDTH-1:0]      = blink;
      REG_PRESCALE: readdata[PRESCALE_W-1:0] = prescale;
      REG_DUTY:     readdata[PWM_BITS-1:0]   = duty;
      REG_STATUS: begin
        readdata[STATUS_PHASE_BIT] = phase;
        readdata[STATUS_PWM_BIT]   = pwm_on;
      end
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_dvp_led_pwm_pio.sv
// Directed bench for the LED PIO: readback, set/clear, blink timing, PWM, polarity and async reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_dvp_led_pwm_pio;
  import dvp_led_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_inv;
  logic [3:0]  out_port;
  logic [3:0]  out_port_inv;

  always #5 clk = ~clk;

  dvp_led_pwm_pio #(
    .WIDTH(4), .RESET_VALUE(4'h0), .PWM_BITS(4), .PRESCALE_RESET(24'd3), .INVERT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  dvp_led_pwm_pio #(
    .WIDTH(4), .RESET_VALUE(4'h3), .PWM_BITS(4), .PRESCALE_RESET(24'd3), .INVERT(1'b1)
  ) dut_inv (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_inv), .out_port(out_port_inv)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0x%0h, no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp, input bit inv);
    address = a;
    #1;
    expect_val(tag, exp);
    compare(inv ? readdata_inv : readdata);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] exp, input bit inv);
    expect_val(tag, {28'h0, exp});
    compare({28'h0, (inv ? out_port_inv : out_port)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Count cycles with LED0 lit over one full 16-cycle PWM period.
  task automatic pwm_window(input string tag, input int exp_on);
    int on_cnt;
    int stray;
    on_cnt = 0;
    stray  = 0;
    expect_val(tag, exp_on);
    expect_val({tag, "_stray"}, 0);
    for (int i = 0; i < 16; i++) begin
      if (out_port[0]) on_cnt++;
      if (out_port[3:1] != 3'b000) stray++;
      tick();
    end
    compare(on_cnt);
    compare(stray);
  endtask

  logic [3:0] blink_a [6];
  logic [3:0] blink_b [5];

  initial begin
    blink_a = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
    blink_b = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF};

    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    #2;

    // Reset state
    chk_out("rst_out", 4'h0, 1'b0);
    chk_out("rst_out_inv", 4'hC, 1'b1);
    rd("rst_data", REG_DATA, 32'h0, 1'b0);
    rd("rst_duty", REG_DUTY, 32'hF, 1'b0);
    rd("rst_status", REG_STATUS, 32'h3, 1'b0);
    rd("rst_prescale", REG_PRESCALE, 32'h3, 1'b0);
    rd("rst_data_inv", REG_DATA, 32'h3, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // DATA write latency and readback
    wr(REG_DATA, 32'hA);
    chk_out("data_lat1", 4'h0, 1'b0);
    tick();
    chk_out("data_lat2", 4'hA, 1'b0);
    chk_out("data_inv", 4'h5, 1'b1);
    rd("data_rd_a", REG_DATA, 32'hA, 1'b0);
    wr(REG_DATA, 32'hFFFF_FFF5);
    rd("data_rd_trunc", REG_DATA, 32'h5, 1'b0);

    // Set / clear
    wr(REG_SET, 32'h2);
    rd("set_rd", REG_DATA, 32'h7, 1'b0);
    wr(REG_CLR, 32'h4);
    rd("clr_rd", REG_DATA, 32'h3, 1'b0);
    rd("set_reads0", REG_SET, 32'h0, 1'b0);
    rd("clr_reads0", REG_CLR, 32'h0, 1'b0);
    wr(REG_SET, 32'h0);
    rd("set0_noop", REG_DATA, 32'h3, 1'b0);
    wr(REG_CLR, 32'h0);
    rd("clr0_noop", REG_DATA, 32'h3, 1'b0);
    wr(REG_RESERVED, 32'hFFFF_FFFF);
    rd("rsvd_reads0", REG_RESERVED, 32'h0, 1'b0);
    rd("rsvd_no_effect", REG_DATA, 32'h3, 1'b0);
    wr(REG_PRESCALE, 32'hFF12_3456);
    rd("prescale_24b", REG_PRESCALE, 32'h0012_3456, 1'b0);
    wr(REG_DUTY, 32'hFFFF_FFF5);
    rd("duty_trunc", REG_DUTY, 32'h5, 1'b0);

    // Blink: known phase after reset, then a PRESCALE write restarts the count
    do_reset();
    wr(REG_DATA, 32'hF);
    wr(REG_BLINK, 32'h1);
    wr(REG_PRESCALE, 32'h3);
    chk_out("blink_start", 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("blink_a%0d", i), blink_a[i], 1'b0);
    end
    wr(REG_PRESCALE, 32'h3);
    chk_out("blink_reload", 4'hE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("blink_b%0d", i), blink_b[i], 1'b0);
    end

    // Asynchronous reset while blinking with phase low
    tick();
    tick();
    tick();
    rd("pre_rst_status", REG_STATUS, 32'h2, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk_out("midrst_out", 4'h0, 1'b0);
    chk_out("midrst_out_inv", 4'hC, 1'b1);
    rd("midrst_status", REG_STATUS, 32'h3, 1'b0);
    rd("midrst_blink", REG_BLINK, 32'h0, 1'b0);
    rd("midrst_blink_inv", REG_BLINK, 32'h0, 1'b1);
    rd("midrst_data_inv", REG_DATA, 32'h3, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // PWM brightness
    wr(REG_DATA, 32'h1);
    wr(REG_DUTY, 32'h4);
    tick();
    pwm_window("pwm_duty4", 4);
    wr(REG_DUTY, 32'h0);
    tick();
    pwm_window("pwm_duty0", 0);
    wr(REG_DUTY, 32'hF);
    tick();
    pwm_window("pwm_dutyF", 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
